// File: rtl/nnrv_pkg.sv
// ============================================================================
// Module      : nnrv_pkg
// Description : Shared definitions for the NNRV memory stage: FSM state
//               encoding, access-size codes and mask-to-size decoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nnrv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } mem_size_e;

    // Access size is implied by how many byte lanes are enabled.
    function automatic mem_size_e size_from_mask(input logic [7:0] mask);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, mask[i]};
        end
        case (cnt)
            4'd1:    size_from_mask = SZ_BYTE;
            4'd2:    size_from_mask = SZ_HALF;
            4'd4:    size_from_mask = SZ_WORD;
            default: size_from_mask = SZ_DWORD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/nnrv_mem_ldext.sv
// ============================================================================
// Module      : nnrv_mem_ldext
// Description : Combinational load extraction: lane shift plus sign/zero
//               extension from the accessed size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nnrv_mem_ldext
    import nnrv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_offs,
    input  logic [1:0]      i_size,
    input  logic            i_sign,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_sh;

    assign w_sh = i_rdata >> {i_offs, 3'b000};

    always_comb begin
        o_data = w_sh;
        case (mem_size_e'(i_size))
            SZ_BYTE:  o_data = {{(XLEN-8){i_sign & w_sh[7]}},   w_sh[7:0]};
            SZ_HALF:  o_data = {{(XLEN-16){i_sign & w_sh[15]}}, w_sh[15:0]};
            SZ_WORD:  o_data = {{(XLEN-32){i_sign & w_sh[31]}}, w_sh[31:0]};
            default:  o_data = w_sh;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/nnrv_mem.sv
// ============================================================================
// Module      : nnrv_mem
// Description : Pipeline memory stage: IDLE/REQ/DONE handshake to RAM,
//               registered writeback and hazard signalling.
//               Optional alignment check via NNRV_MEM_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nnrv_mem
    import nnrv_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MASK_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ex_rd_en,
    input  logic [4:0]            i_ex_rd,
    input  logic [XLEN-1:0]       i_ex_rd_reg,
    input  logic                  i_ex_ram_rd_en,
    input  logic                  i_ex_ram_wr_en,
    input  logic [XLEN-1:0]       i_ex_ram_addr,
    input  logic [XLEN-1:0]       i_ex_ram_data,
    input  logic [MASK_WIDTH-1:0] i_ex_ram_mask,
    input  logic                  i_ex_sign,
    output logic                  o_ram_req,
    output logic                  o_ram_we,
    output logic [XLEN-1:0]       o_ram_addr,
    output logic [XLEN-1:0]       o_ram_wdata,
    output logic [MASK_WIDTH-1:0] o_ram_mask,
    input  logic                  i_ram_ack,
    input  logic [XLEN-1:0]       i_ram_rdata,
    output logic                  o_wb_rd_en,
    output logic [4:0]            o_wb_rd,
    output logic [XLEN-1:0]       o_wb_rd_reg,
    output logic                  o_stall,
`ifdef NNRV_MEM_ALIGN_CHK_EN
    output logic                  o_mem_fault,
`endif
    output logic                  o_id_rd_ready
);

    mem_state_e            r_state;
    mem_state_e            w_state_nxt;
    mem_size_e             w_size;
    mem_size_e             r_size;
    logic                  w_access;
    logic                  w_fault;
    logic                  r_ram_req;
    logic                  r_ram_we;
    logic [XLEN-1:0]       r_ram_addr;
    logic [XLEN-1:0]       r_ram_wdata;
    logic [MASK_WIDTH-1:0] r_ram_mask;
    logic [2:0]            r_offs;
    logic                  r_sign;
    logic                  r_store;
    logic [4:0]            r_rd;
    logic                  r_rd_en;
    logic                  r_wb_rd_en;
    logic [4:0]            r_wb_rd;
    logic [XLEN-1:0]       r_wb_rd_reg;
    logic                  r_id_rd_ready;
    logic [XLEN-1:0]       w_ld_data;

    assign w_access = i_ex_ram_rd_en | i_ex_ram_wr_en;
    assign w_size   = size_from_mask(i_ex_ram_mask);

`ifdef NNRV_MEM_ALIGN_CHK_EN
    logic r_fault;

    always_comb begin
        case (w_size)
            SZ_HALF:  w_fault = i_ex_ram_addr[0];
            SZ_WORD:  w_fault = |i_ex_ram_addr[1:0];
            SZ_DWORD: w_fault = |i_ex_ram_addr[2:0];
            default:  w_fault = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (r_state == ST_IDLE) & w_access & w_fault;
        end
    end

    assign o_mem_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_access && !w_fault) w_state_nxt = ST_REQ;
            ST_REQ:  if (i_ram_ack)            w_state_nxt = ST_DONE;
            ST_DONE:                           w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ram_req     <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_ram_mask    <= '0;
            r_offs        <= '0;
            r_size        <= SZ_BYTE;
            r_sign        <= 1'b0;
            r_store       <= 1'b0;
            r_rd          <= '0;
            r_rd_en       <= 1'b0;
            r_wb_rd_en    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_rd_reg   <= '0;
            r_id_rd_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access && !w_fault) begin
                        r_ram_req     <= 1'b1;
                        r_ram_we      <= i_ex_ram_wr_en;
                        r_ram_addr    <= {i_ex_ram_addr[XLEN-1:3], 3'b000};
                        r_ram_wdata   <= i_ex_ram_data;
                        r_ram_mask    <= i_ex_ram_mask;
                        r_offs        <= i_ex_ram_addr[2:0];
                        r_size        <= w_size;
                        r_sign        <= i_ex_sign;
                        r_store       <= i_ex_ram_wr_en;
                        r_rd          <= i_ex_rd;
                        // Stores and x0 targets never write back.
                        r_rd_en       <= i_ex_rd_en & (|i_ex_rd) & ~i_ex_ram_wr_en;
                        r_wb_rd_en    <= 1'b0;
                        r_id_rd_ready <= 1'b0;
                    end else if (w_access) begin
                        r_wb_rd_en    <= 1'b0;
                        r_id_rd_ready <= 1'b0;
                    end else begin
                        r_wb_rd_en    <= i_ex_rd_en & (|i_ex_rd);
                        r_wb_rd       <= i_ex_rd;
                        r_wb_rd_reg   <= i_ex_rd_reg;
                        r_id_rd_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_ram_ack) begin
                        r_ram_req     <= 1'b0;
                        r_ram_we      <= 1'b0;
                        r_wb_rd_en    <= r_rd_en;
                        r_wb_rd       <= r_rd;
                        r_wb_rd_reg   <= w_ld_data;
                        r_id_rd_ready <= ~r_store;
                    end
                end
                default: begin
                    r_wb_rd_en    <= 1'b0;
                    r_id_rd_ready <= 1'b0;
                end
            endcase
        end
    end

    nnrv_mem_ldext #(
        .XLEN (XLEN)
    ) u_ldext (
        .i_rdata (i_ram_rdata),
        .i_offs  (r_offs),
        .i_size  (r_size),
        .i_sign  (r_sign),
        .o_data  (w_ld_data)
    );

    assign o_stall       = ((r_state == ST_IDLE) & w_access) | (r_state == ST_REQ) |
                           (r_state == ST_DONE);
    assign o_ram_req     = r_ram_req;
    assign o_ram_we      = r_ram_we;
    assign o_ram_addr    = r_ram_addr;
    assign o_ram_wdata   = r_ram_wdata;
    assign o_ram_mask    = r_ram_mask;
    assign o_wb_rd_en    = r_wb_rd_en;
    assign o_wb_rd       = r_wb_rd;
    assign o_wb_rd_reg   = r_wb_rd_reg;
    assign o_id_rd_ready = r_id_rd_ready;

endmodule

`default_nettype wire

// File: tb/tb_nnrv_mem.sv
// ============================================================================
// Module      : tb_nnrv_mem
// Description : Directed self-checking bench for nnrv_mem (loads, stores,
//               ALU passthrough, reset abort; alignment fault when
//               NNRV_MEM_ALIGN_CHK_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nnrv_mem;

    logic        clk;
    logic        rst_n;
    logic        ex_rd_en;
    logic [4:0]  ex_rd;
    logic [63:0] ex_rd_reg;
    logic        ex_ram_rd_en;
    logic        ex_ram_wr_en;
    logic [63:0] ex_ram_addr;
    logic [63:0] ex_ram_data;
    logic [7:0]  ex_ram_mask;
    logic        ex_sign;
    logic        ram_req;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_mask;
    logic        ram_ack;
    logic [63:0] ram_rdata;
    logic        wb_rd_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_rd_reg;
    logic        stall;
    logic        id_rd_ready;
`ifdef NNRV_MEM_ALIGN_CHK_EN
    logic        mem_fault;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Values captured by run_mem for the caller to check
    int          st_cnt;
    int          req_hi;
    logic        c_we;
    logic [63:0] c_addr;
    logic [63:0] c_wdata;
    logic [7:0]  c_mask;
    logic        d_en;
    logic [4:0]  d_rd;
    logic [63:0] d_reg;
    logic        d_rdy;
    logic        d_req;

    nnrv_mem #(
        .XLEN       (64),
        .MASK_WIDTH (8)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_ex_rd_en     (ex_rd_en),
        .i_ex_rd        (ex_rd),
        .i_ex_rd_reg    (ex_rd_reg),
        .i_ex_ram_rd_en (ex_ram_rd_en),
        .i_ex_ram_wr_en (ex_ram_wr_en),
        .i_ex_ram_addr  (ex_ram_addr),
        .i_ex_ram_data  (ex_ram_data),
        .i_ex_ram_mask  (ex_ram_mask),
        .i_ex_sign      (ex_sign),
        .o_ram_req      (ram_req),
        .o_ram_we       (ram_we),
        .o_ram_addr     (ram_addr),
        .o_ram_wdata    (ram_wdata),
        .o_ram_mask     (ram_mask),
        .i_ram_ack      (ram_ack),
        .i_ram_rdata    (ram_rdata),
        .o_wb_rd_en     (wb_rd_en),
        .o_wb_rd        (wb_rd),
        .o_wb_rd_reg    (wb_rd_reg),
        .o_stall        (stall),
`ifdef NNRV_MEM_ALIGN_CHK_EN
        .o_mem_fault    (mem_fault),
`endif
        .o_id_rd_ready  (id_rd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one memory access starting at posedge+1 in IDLE, acks it in the
    // ack_at-th REQ cycle and returns at posedge+1 of the following IDLE cycle.
    task automatic run_mem(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] mask, input logic sgn, input logic [4:0] rd,
                           input int ack_at, input logic [63:0] rdata);
        ex_ram_rd_en = ~wr;
        ex_ram_wr_en = wr;
        ex_ram_addr  = addr;
        ex_ram_data  = data;
        ex_ram_mask  = mask;
        ex_sign      = sgn;
        ex_rd_en     = 1'b1;
        ex_rd        = rd;
        ex_rd_reg    = 64'hAAAA_AAAA_AAAA_AAAA;
        st_cnt       = 0;
        req_hi       = 0;
        #1;
        if (stall) st_cnt++;
        step();
        for (int c = 1; c <= ack_at; c++) begin
            if (stall) st_cnt++;
            if (ram_req) req_hi++;
            c_we    = ram_we;
            c_addr  = ram_addr;
            c_wdata = ram_wdata;
            c_mask  = ram_mask;
            if (c == ack_at) begin
                ram_ack   = 1'b1;
                ram_rdata = rdata;
            end
            step();
            ram_ack   = 1'b0;
            ram_rdata = '0;
        end
        if (stall) st_cnt++;
        d_en  = wb_rd_en;
        d_rd  = wb_rd;
        d_reg = wb_rd_reg;
        d_rdy = id_rd_ready;
        d_req = ram_req;
        ex_ram_rd_en = 1'b0;
        ex_ram_wr_en = 1'b0;
        ex_rd_en     = 1'b0;
        step();
    endtask

    initial begin
        rst_n        = 1'b0;
        ex_rd_en     = 1'b0;
        ex_rd        = '0;
        ex_rd_reg    = '0;
        ex_ram_rd_en = 1'b0;
        ex_ram_wr_en = 1'b0;
        ex_ram_addr  = '0;
        ex_ram_data  = '0;
        ex_ram_mask  = '0;
        ex_sign      = 1'b0;
        ram_ack      = 1'b0;
        ram_rdata    = '0;

        // Reset state
        #22;
        chk("rst_req",   ram_req, 0);
        chk("rst_we",    ram_we, 0);
        chk("rst_addr",  ram_addr, 0);
        chk("rst_wben",  wb_rd_en, 0);
        chk("rst_rdy",   id_rd_ready, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;
        step();

        // ALU passthrough
        ex_rd_en  = 1'b1;
        ex_rd     = 5'd3;
        ex_rd_reg = 64'd5;
        #1;
        chk("add_stall", stall, 0);
        step();
        chk("add_wben", wb_rd_en, 1);
        chk("add_rd",   wb_rd, 3);
        chk("add_val",  wb_rd_reg, 64'd5);
        chk("add_rdy",  id_rd_ready, 1);

        // rd = x0 never writes back
        ex_rd     = 5'd0;
        ex_rd_reg = 64'd7;
        step();
        chk("x0_wben", wb_rd_en, 0);
        ex_rd_en = 1'b0;

        // LD, ack in third REQ cycle
        run_mem(1'b0, 64'h1000, '0, 8'hFF, 1'b0, 5'd5, 3, 64'h8877665544332211);
        chk("ld_stalls", st_cnt, 5);
        chk("ld_reqhi",  req_hi, 3);
        chk("ld_addr",   c_addr, 64'h1000);
        chk("ld_we",     c_we, 0);
        chk("ld_wben",   d_en, 1);
        chk("ld_rd",     d_rd, 5);
        chk("ld_val",    d_reg, 64'h8877665544332211);
        chk("ld_rdy",    d_rdy, 1);
        chk("ld_reqoff", d_req, 0);
        chk("ld_wbclr",  wb_rd_en, 0);
        chk("ld_idle",   stall, 0);

        // LB signed / unsigned, minimum latency, back-to-back
        run_mem(1'b0, 64'h1003, '0, 8'h08, 1'b1, 5'd6, 1, 64'h1122334480665544);
        chk("lb_stalls", st_cnt, 3);
        chk("lb_addr",   c_addr, 64'h1000);
        chk("lb_mask",   c_mask, 8'h08);
        chk("lbs_val",   d_reg, 64'hFFFFFFFFFFFFFF80);
        run_mem(1'b0, 64'h1003, '0, 8'h08, 1'b0, 5'd6, 1, 64'h1122334480665544);
        chk("lbu_val",   d_reg, 64'h80);

        // LH signed, LW unsigned
        run_mem(1'b0, 64'h1006, '0, 8'hC0, 1'b1, 5'd8, 2, 64'hF234000000000000);
        chk("lh_val",    d_reg, 64'hFFFFFFFFFFFFF234);
        run_mem(1'b0, 64'h1004, '0, 8'hF0, 1'b0, 5'd9, 1, 64'h8765432100000000);
        chk("lwu_val",   d_reg, 64'h0000000087654321);

        // SW
        run_mem(1'b1, 64'h2004, 64'hDEADBEEF00000000, 8'hF0, 1'b0, 5'd7, 2, '0);
        chk("sw_stalls", st_cnt, 4);
        chk("sw_addr",   c_addr, 64'h2000);
        chk("sw_we",     c_we, 1);
        chk("sw_mask",   c_mask, 8'hF0);
        chk("sw_wdata",  c_wdata, 64'hDEADBEEF00000000);
        chk("sw_wben",   d_en, 0);
        chk("sw_rdy",    d_rdy, 0);

        // Reset during REQ aborts; late ack ignored
        ex_ram_rd_en = 1'b1;
        ex_ram_addr  = 64'h3000;
        ex_ram_mask  = 8'hFF;
        ex_rd_en     = 1'b1;
        ex_rd        = 5'd4;
        step();
        chk("abort_req", ram_req, 1);
        ex_ram_rd_en = 1'b0;
        ex_rd_en     = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("abort_drop", ram_req, 0);
        step();
        rst_n = 1'b1;
        step();
        ram_ack   = 1'b1;
        ram_rdata = 64'h1234;
        step();
        ram_ack   = 1'b0;
        ram_rdata = '0;
        chk("late_req",   ram_req, 0);
        chk("late_wben",  wb_rd_en, 0);
        chk("late_stall", stall, 0);
        step();
        chk("late_wben2", wb_rd_en, 0);
        run_mem(1'b0, 64'h3000, '0, 8'hFF, 1'b0, 5'd4, 2, 64'h0123456789ABCDEF);
        chk("post_val",  d_reg, 64'h0123456789ABCDEF);
        chk("post_wben", d_en, 1);

`ifdef NNRV_MEM_ALIGN_CHK_EN
        // Misaligned LW
        ex_ram_rd_en = 1'b1;
        ex_ram_addr  = 64'h1002;
        ex_ram_mask  = 8'h0F;
        ex_rd_en     = 1'b1;
        ex_rd        = 5'd2;
        step();
        chk("mis_fault", mem_fault, 1);
        chk("mis_req",   ram_req, 0);
        chk("mis_wben",  wb_rd_en, 0);
        ex_ram_rd_en = 1'b0;
        ex_rd_en     = 1'b0;
        step();
        chk("mis_pulse", mem_fault, 0);
        chk("mis_req2",  ram_req, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
